// File: rtl/point_delta_unit.sv
// Anchor-based point differencer: emits |dx|,|dy| between consecutive accepted
// points through a small circular FIFO for the downstream magnitude stage.
module point_delta_unit #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter bit SKIP_ZERO = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic [WIDTH-1:0]         pt_x,
   input  logic [WIDTH-1:0]         pt_y,
   input  logic                     pt_valid,
   output logic                     pt_ready,
   output logic [WIDTH-1:0]         d_x,
   output logic [WIDTH-1:0]         d_y,
   output logic                     d_valid,
   input  logic                     d_ready,
   output logic [15:0]              pair_count,
   output logic [$clog2(DEPTH):0]   fifo_level
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic {NO_ANCHOR, ARMED} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     ax_q, ax_d, ay_q, ay_d;
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]          level_q, level_d;
   logic [15:0]          pair_count_q, pair_count_d;
   logic [2*WIDTH-1:0]   mem_q [DEPTH];
   logic [2*WIDTH-1:0]   mem_d [DEPTH];

   logic                 full, in_xfer, out_xfer, push;
   logic [WIDTH-1:0]     dx, dy;

   always_comb begin
      full     = (level_q == (AW+1)'(DEPTH));
      pt_ready = (state_q == NO_ANCHOR) || !full;
      d_valid  = (level_q != '0);
      in_xfer  = pt_valid && pt_ready;
      out_xfer = d_valid && d_ready;

      dx = (pt_x >= ax_q) ? pt_x - ax_q : ax_q - pt_x;
      dy = (pt_y >= ay_q) ? pt_y - ay_q : ay_q - pt_y;

      // clear suppresses the push but the point still becomes the new anchor
      push = in_xfer && (state_q == ARMED) && !clear &&
             !(SKIP_ZERO && (dx == '0) && (dy == '0));

      state_d = state_q;
      ax_d    = ax_q;
      ay_d    = ay_q;
      if (in_xfer) begin
         state_d = ARMED;
         ax_d    = pt_x;
         ay_d    = pt_y;
      end else if (clear) begin
         state_d = NO_ANCHOR;
      end

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = {dx, dy};
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (out_xfer) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      level_d = level_q;
      if (push && !out_xfer) begin
         level_d = level_q + (AW+1)'(1);
      end else if (!push && out_xfer) begin
         level_d = level_q - (AW+1)'(1);
      end

      pair_count_d = pair_count_q;
      if (push && (pair_count_q != '1)) begin
         pair_count_d = pair_count_q + 16'd1;
      end

      d_x        = d_valid ? mem_q[rd_ptr_q][2*WIDTH-1:WIDTH] : '0;
      d_y        = d_valid ? mem_q[rd_ptr_q][WIDTH-1:0]       : '0;
      pair_count = pair_count_q;
      fifo_level = level_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= NO_ANCHOR;
         ax_q         <= '0;
         ay_q         <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         pair_count_q <= '0;
      end else begin
         state_q      <= state_d;
         ax_q         <= ax_d;
         ay_q         <= ay_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         pair_count_q <= pair_count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_point_delta_unit.sv
// Bench for point_delta_unit: scenario tasks against a queue-based reference
// model, with one instance per SKIP_ZERO setting.
module tb_point_delta_unit;
   localparam int W  = 8;
   localparam int D  = 4;
   localparam int LW = $clog2(D) + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, clear, pt_valid, d_ready, sel;
   logic [W-1:0]  pt_x, pt_y;
   logic          rdy0, dv0, rdy1, dv1;
   logic [W-1:0]  dx0, dy0, dx1, dy1;
   logic [15:0]   cnt0, cnt1;
   logic [LW-1:0] lvl0, lvl1;

   logic          c_ready, c_valid;
   logic [W-1:0]  c_dx, c_dy;
   logic [15:0]   c_cnt;
   logic [LW-1:0] c_lvl;

   assign c_ready = sel ? rdy1 : rdy0;
   assign c_valid = sel ? dv1  : dv0;
   assign c_dx    = sel ? dx1  : dx0;
   assign c_dy    = sel ? dy1  : dy0;
   assign c_cnt   = sel ? cnt1 : cnt0;
   assign c_lvl   = sel ? lvl1 : lvl0;

   point_delta_unit #(.WIDTH(W), .DEPTH(D), .SKIP_ZERO(1'b0)) dut0 (
      .clk(clk), .rst(rst), .clear(clear), .pt_x(pt_x), .pt_y(pt_y),
      .pt_valid(pt_valid), .pt_ready(rdy0), .d_x(dx0), .d_y(dy0),
      .d_valid(dv0), .d_ready(d_ready), .pair_count(cnt0), .fifo_level(lvl0));

   point_delta_unit #(.WIDTH(W), .DEPTH(D), .SKIP_ZERO(1'b1)) dut1 (
      .clk(clk), .rst(rst), .clear(clear), .pt_x(pt_x), .pt_y(pt_y),
      .pt_valid(pt_valid), .pt_ready(rdy1), .d_x(dx1), .d_y(dy1),
      .d_valid(dv1), .d_ready(d_ready), .pair_count(cnt1), .fifo_level(lvl1));

   int checks = 0;
   int errors = 0;

   // reference model: anchor flag/value, pending delta queue, push counter
   bit            anchored, accepted;
   int            ax, ay, m_cnt;
   logic [W-1:0]  qx[$], qy[$];
   logic [W-1:0]  ex[$], ey[$];
   logic [W-1:0]  ox[$], oy[$];

   task automatic step(input bit v, input int x, input int y, input bit dr, input bit clr);
      int  ddx, ddy;
      bit  rdy;
      pt_valid = v; pt_x = W'(x); pt_y = W'(y); d_ready = dr; clear = clr;
      rdy      = !anchored || (qx.size() < D);
      accepted = v && rdy;
      if (c_valid === 1'b1 && dr) begin
         ox.push_back(c_dx); oy.push_back(c_dy);
      end
      if (dr && qx.size() > 0) begin
         ex.push_back(qx.pop_front()); ey.push_back(qy.pop_front());
      end
      if (accepted) begin
         if (anchored && !clr) begin
            ddx = (x > ax) ? x - ax : ax - x;
            ddy = (y > ay) ? y - ay : ay - y;
            if (!(sel && ddx == 0 && ddy == 0)) begin
               qx.push_back(W'(ddx)); qy.push_back(W'(ddy));
               if (m_cnt < 65535) m_cnt++;
            end
         end
         ax = x; ay = y; anchored = 1'b1;
      end else if (clr) begin
         anchored = 1'b0;
      end
      @(posedge clk); #1;
      pt_valid = 1'b0; clear = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1; pt_valid = 1'b0; clear = 1'b0; d_ready = 1'b0; pt_x = '0; pt_y = '0;
      repeat (cycles) @(posedge clk);
      #1; rst = 1'b0;
      anchored = 1'b0; ax = 0; ay = 0; m_cnt = 0;
      qx.delete(); qy.delete(); ex.delete(); ey.delete(); ox.delete(); oy.delete();
   endtask

   task automatic test_reset;
      sel = 1'b0;
      do_reset(2);
      checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", c_ready); end
      checks++; if (c_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", c_valid); end
      checks++; if (c_dx !== 8'd0 || c_dy !== 8'd0) begin errors++; $display("FAIL reset_data: got (%0d,%0d) want (0,0)", c_dx, c_dy); end
      checks++; if (c_cnt !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", c_cnt); end
      checks++; if (c_lvl !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", c_lvl); end
      step(1, 10, 20, 1, 0);
      for (int i = 0; i < 3; i++) begin
         checks++; if (c_valid !== 1'b0 || c_ready !== 1'b1) begin
            errors++; $display("FAIL single_point: valid %b ready %b want 0 1", c_valid, c_ready);
         end
         step(0, 0, 0, 1, 0);
      end
      checks++; if (c_cnt !== 16'd0) begin errors++; $display("FAIL single_point_count: got %0d want 0", c_cnt); end
   endtask

   task automatic test_sign;
      int wx[2] = '{7, 252};
      int wy[2] = '{5, 25};
      sel = 1'b0;
      do_reset(1);
      step(1, 10, 20, 1, 0);
      step(1, 3, 25, 1, 0);
      checks++; if (c_valid !== 1'b1 || c_dx !== 8'd7 || c_dy !== 8'd5) begin
         errors++; $display("FAIL sign_latency: valid %b data (%0d,%0d) want 1 (7,5)", c_valid, c_dx, c_dy);
      end
      step(1, 255, 0, 1, 0);
      repeat (3) step(0, 0, 0, 1, 0);
      checks++; if (ox.size() != 2) begin errors++; $display("FAIL sign_len: got %0d want 2", ox.size()); end
      for (int i = 0; i < 2 && i < ox.size(); i++) begin
         checks++; if (ox[i] !== W'(wx[i]) || oy[i] !== W'(wy[i])) begin
            errors++; $display("FAIL sign_data[%0d]: got (%0d,%0d) want (%0d,%0d)", i, ox[i], oy[i], wx[i], wy[i]);
         end
      end
      checks++; if (c_cnt !== 16'd2) begin errors++; $display("FAIL sign_count: got %0d want 2", c_cnt); end
   endtask

   task automatic test_full;
      int  pts[6] = '{0, 1, 3, 6, 10, 15};
      bit  done = 1'b0;
      sel = 1'b0;
      do_reset(1);
      for (int i = 0; i < 5; i++) begin
         if (i == 4) begin
            checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL full_early: ready %b want 1", c_ready); end
         end
         step(1, pts[i], pts[i], 0, 0);
      end
      checks++; if (c_ready !== 1'b0 || c_lvl !== LW'(4)) begin
         errors++; $display("FAIL full_flag: ready %b level %0d want 0 4", c_ready, c_lvl);
      end
      step(1, 15, 15, 0, 0);
      step(1, 15, 15, 0, 0);
      checks++; if (c_lvl !== LW'(4) || c_cnt !== 16'd4) begin
         errors++; $display("FAIL full_stall: level %0d count %0d want 4 4", c_lvl, c_cnt);
      end
      step(1, 15, 15, 1, 0);
      checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL full_release: ready %b want 1", c_ready); end
      for (int k = 0; k < 10 && !done; k++) begin
         step(1, 15, 15, 1, 0);
         done = accepted;
      end
      repeat (D + 2) step(0, 0, 0, 1, 0);
      checks++; if (ox.size() != 5) begin errors++; $display("FAIL full_len: got %0d want 5", ox.size()); end
      for (int i = 0; i < 5 && i < ox.size(); i++) begin
         checks++; if (ox[i] !== W'(i + 1) || oy[i] !== W'(i + 1)) begin
            errors++; $display("FAIL full_data[%0d]: got (%0d,%0d) want (%0d,%0d)", i, ox[i], oy[i], i + 1, i + 1);
         end
      end
   endtask

   task automatic test_back_to_back;
      sel = 1'b0;
      do_reset(1);
      step(1, 0, 0, 0, 0);
      step(1, 10, 20, 0, 0);
      step(1, 30, 5, 0, 0);
      for (int i = 0; i < 20; i++) begin
         step(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1, 0);
         checks++; if (c_lvl !== LW'(2) || c_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_level[%0d]: level %0d valid %b want 2 1", i, c_lvl, c_valid);
         end
      end
      repeat (D + 2) step(0, 0, 0, 1, 0);
      checks++; if (ox.size() != 22 || ex.size() != 22) begin
         errors++; $display("FAIL b2b_len: got %0d want 22", ox.size());
      end
      for (int i = 0; i < ox.size() && i < ex.size(); i++) begin
         checks++; if (ox[i] !== ex[i] || oy[i] !== ey[i]) begin
            errors++; $display("FAIL b2b_data[%0d]: got (%0d,%0d) want (%0d,%0d)", i, ox[i], oy[i], ex[i], ey[i]);
         end
      end
   endtask

   task automatic test_clear;
      sel = 1'b0;
      do_reset(1);
      step(1, 50, 50, 1, 0);
      step(1, 60, 70, 1, 0);
      step(1, 100, 100, 1, 1);
      step(1, 90, 130, 1, 0);
      repeat (3) step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 1);
      step(1, 7, 7, 1, 0);
      repeat (3) step(0, 0, 0, 1, 0);
      checks++; if (ox.size() != 2) begin errors++; $display("FAIL clear_len: got %0d want 2", ox.size()); end
      if (ox.size() >= 2) begin
         checks++; if (ox[0] !== 8'd10 || oy[0] !== 8'd20 || ox[1] !== 8'd10 || oy[1] !== 8'd30) begin
            errors++; $display("FAIL clear_data: got (%0d,%0d) (%0d,%0d) want (10,20) (10,30)", ox[0], oy[0], ox[1], oy[1]);
         end
      end
      checks++; if (c_cnt !== 16'd2) begin errors++; $display("FAIL clear_count: got %0d want 2", c_cnt); end
   endtask

   task automatic test_skip_zero;
      sel = 1'b1;
      do_reset(2);
      step(1, 5, 5, 1, 0);
      step(1, 5, 5, 1, 0);
      step(1, 8, 5, 1, 0);
      repeat (3) step(0, 0, 0, 1, 0);
      checks++; if (ox.size() != 1) begin errors++; $display("FAIL skip_len: got %0d want 1", ox.size()); end
      if (ox.size() >= 1) begin
         checks++; if (ox[0] !== 8'd3 || oy[0] !== 8'd0) begin
            errors++; $display("FAIL skip_data: got (%0d,%0d) want (3,0)", ox[0], oy[0]);
         end
      end
      checks++; if (c_cnt !== 16'd1) begin errors++; $display("FAIL skip_count: got %0d want 1", c_cnt); end
      step(1, 1, 1, 0, 0);
      step(1, 2, 3, 0, 0);
      checks++; if (c_valid !== 1'b1) begin errors++; $display("FAIL skip_prerst: valid %b want 1", c_valid); end
      do_reset(1);
      checks++; if (c_valid !== 1'b0 || c_lvl !== '0 || c_cnt !== 16'd0) begin
         errors++; $display("FAIL midreset: valid %b level %0d count %0d want 0 0 0", c_valid, c_lvl, c_cnt);
      end
   endtask

   task automatic test_random(input bit s, input int maxv);
      logic [LW-1:0] e_lvl;
      bit            e_rdy;
      sel = s;
      do_reset(1);
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, int'($urandom_range(0, maxv)), int'($urandom_range(0, maxv)),
              $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
         e_lvl = LW'(qx.size());
         e_rdy = !anchored || (qx.size() < D);
         checks++; if (c_lvl !== e_lvl || c_ready !== e_rdy || c_cnt !== 16'(m_cnt)) begin
            errors++; $display("FAIL rand%0d_state[%0d]: level %0d ready %b count %0d want %0d %b %0d",
                               s, i, c_lvl, c_ready, c_cnt, e_lvl, e_rdy, m_cnt);
         end
      end
      repeat (D + 2) step(0, 0, 0, 1, 0);
      checks++; if (ox.size() != ex.size()) begin
         errors++; $display("FAIL rand%0d_len: got %0d want %0d", s, ox.size(), ex.size());
      end
      for (int i = 0; i < ox.size() && i < ex.size(); i++) begin
         checks++; if (ox[i] !== ex[i] || oy[i] !== ey[i]) begin
            errors++; $display("FAIL rand%0d_data[%0d]: got (%0d,%0d) want (%0d,%0d)", s, i, ox[i], oy[i], ex[i], ey[i]);
         end
      end
   endtask

   initial begin
      sel = 1'b0; rst = 1'b1; clear = 1'b0; pt_valid = 1'b0; d_ready = 1'b0; pt_x = '0; pt_y = '0;
      test_reset;
      test_sign;
      test_full;
      test_back_to_back;
      test_clear;
      test_skip_zero;
      test_random(1'b0, 255);
      test_random(1'b1, 3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/point_delta_unit.md
# point_delta_unit

Upstream feeder for the Euclidean-magnitude stage. Accepts a stream of 2-D points `(x, y)` over a valid/ready handshake and keeps the most recent point as an anchor. For every new point after the anchor, it computes unsigned absolute deltas `|x - x_prev|` and `|y - y_prev|`. The delta pairs are buffered in a small FIFO, and the downstream stage reads each pair as its `(x, y)` operands.

## Interface
- `WIDTH`, 8: coordinate and delta width in bits.
- `DEPTH`, 4: output FIFO depth in entries; must be a power of 2 and ≥ 2.
- `SKIP_ZERO`, 0: when 1, a delta pair with dx == 0 and dy == 0 is not pushed.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `clear`  in  1: synchronous anchor flush; FIFO contents are kept.
- `pt_x`  in  WIDTH: incoming point x.
- `pt_y`  in  WIDTH: incoming point y.
- `pt_valid`  in  1: incoming point present.
- `pt_ready`  out  1: block can accept a point this cycle.
- `d_x`  out  WIDTH: head-of-FIFO |dx|.
- `d_y`  out  WIDTH: head-of-FIFO |dy|.
- `d_valid`  out  1: FIFO non-empty.
- `d_ready`  in  1: downstream consumes the head entry.
- `pair_count`  out  16: number of delta pairs pushed since reset; saturates at 0xFFFF.
- `fifo_level`  out  $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- State machine, two states:
  - NO_ANCHOR: no previous point.
  - ARMED: anchor registers `ax`/`ay` hold the previous point.
- Transfers:
  - Input transfer occurs when `pt_valid && pt_ready`.
  - Output transfer occurs when `d_valid && d_ready`.
- In NO_ANCHOR, an input transfer loads `ax = pt_x`, `ay = pt_y` and moves to ARMED. Nothing is pushed.
- In ARMED, an input transfer does three things:
  - Computes `dx = (pt_x >= ax) ? pt_x - ax : ax - pt_x`, and dy likewise. Compare and subtract are WIDTH bits, unsigned, with no overflow possible.
  - Pushes `{dx, dy}`, unless `SKIP_ZERO` is 1 and both deltas are 0.
  - Reloads the anchor with the new point in all cases, including a skipped push.
- `pt_ready` is 1 in NO_ANCHOR. In ARMED it is `!full`.
  - It is a function of registered state only. There is no combinational path from `d_ready` to `pt_ready`.
- FIFO behaviour:
  - Circular buffer with read and write pointers that wrap modulo DEPTH.
  - `d_x`/`d_y` are driven from the head entry. They are don't-care when `d_valid` is 0.
  - A push and a pop in the same cycle leave the level unchanged, both pointers advance, and the data is correct.
  - A pop when empty and a push when full cannot occur by construction.
- `pair_count` increments on every actual push and does not increment on skipped pushes. It holds at 0xFFFF.
- `clear`:
  - Returns the FSM to NO_ANCHOR. FIFO, pointers and `pair_count` are unchanged.
  - If `clear` and an input transfer occur in the same cycle, `clear` wins: no push occurs, and the point is loaded as the new anchor with the FSM in ARMED.
  - A simultaneous pop proceeds normally.
- `rst` has priority over everything. On reset:
  - FSM goes to NO_ANCHOR.
  - Anchor is 0, both pointers are 0, level is 0, `pair_count` is 0.
  - Any in-flight FIFO contents are discarded.

## Timing
- Reset values: `pt_ready` = 1, `d_valid` = 0, `d_x` = 0, `d_y` = 0, `pair_count` = 0, `fifo_level` = 0.
- Latency:
  - A point accepted on edge N in ARMED makes `d_valid` = 1 after edge N (visible in cycle N+1) when the FIFO was empty.
  - The deltas pass through exactly one register stage, the FIFO storage. There is no combinational input-to-output bypass.
- Throughput is one point per cycle sustained, provided `d_ready` is held high.
- Full:
  - `pt_ready` drops in the cycle after the DEPTH-th unconsumed push.
  - It rises in the cycle after the first pop.
- Empty: `d_valid` drops in the cycle after the last pop without a concurrent push.
- Outputs are stable while `d_valid && !d_ready`.
- Inputs `pt_x`/`pt_y` are sampled only on an input transfer.

## Test plan
- Reset then a single point: rst for 2 cycles, then point (10, 20). Required: `d_valid` stays 0, `pt_ready` stays 1, `pair_count` = 0.
- Delta sign handling: points (10, 20), (3, 25), (255, 0) with `d_ready` = 1. Required output sequence: (7, 5), then (252, 25); `pair_count` = 2.
- Backpressure and full, DEPTH = 4: `d_ready` = 0 while feeding 6 points (0,0), (1,1), (3,3), (6,6), (10,10), (15,15).
  - `pt_ready` falls after the 5th point is accepted; the 6th point stalls.
  - Then assert `d_ready`. Required outputs: (1,1), (2,2), (3,3), (4,4), (5,5) in order, with no loss or duplication.
- Simultaneous push and pop at level 2 over 20 cycles with pointer wrap. Required: level stays 2 and the data order is preserved.
- `clear` mid-stream: points (50,50), (60,70); assert `clear` together with point (100,100); then point (90,130). Required outputs: (10,20), (10,30) only; `pair_count` = 2.
- `SKIP_ZERO` = 1: points (5,5), (5,5), (8,5). Required: a single output (3,0) and `pair_count` = 1. Reset asserted mid-stream flushes the FIFO and drives `d_valid` to 0 on the next cycle.
